inst_buffer: RTL and testbench

- Circular FIFO of fetch_packet_t between fetch and dispatch_stage.
- Accepts up to `WAY contiguous packets per cycle from fetch.
- Presents the oldest packets to dispatch on inst_buff_out. The number presented is limited by dispatch_stage_num_can_fetch.
- Acts as the producer end of the inst_buff_out / dispatch_stage_num_can_fetch interface. Flushed on squash (mispredict/exception).

---
 rtl/inst_buffer_pkg.sv | 17 +
 rtl/inst_buffer.sv | 100 ++++++++++
 tb/tb_inst_buffer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types and sizing for the fetch-to-dispatch instruction buffer.
package inst_buffer_pkg;

   localparam int WAY             = 3;
   localparam int WAY_CNT_LEN     = $clog2(WAY + 1);
   localparam int INST_BUFF_DEPTH = 16;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_packet_t;

   typedef logic [$clog2(INST_BUFF_DEPTH)-1:0]   inst_buff_idx_t;
   typedef logic [$clog2(INST_BUFF_DEPTH+1)-1:0] inst_buff_cnt_t;

endpackage

// File: rtl/inst_buffer.sv
// Circular FIFO between fetch and dispatch: up to WAY packets in and out per
// cycle, oldest-first presentation, flushed on squash.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH = INST_BUFF_DEPTH
) (
   input  logic                              clock,
   input  logic                              reset,
   input  fetch_packet_t [WAY-1:0]           fetch_in,
   output logic          [WAY_CNT_LEN-1:0]   inst_buff_num_can_accept,
   output fetch_packet_t [WAY-1:0]           inst_buff_out,
   input  logic          [WAY_CNT_LEN-1:0]   dispatch_stage_num_can_fetch,
   input  logic                              squash
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_packet_t          r_entries [DEPTH];
   logic [IDX_W-1:0]       r_head;
   logic [IDX_W-1:0]       r_tail;
   logic [CNT_W-1:0]       r_count;

   logic [CNT_W-1:0]       w_free;
   logic [WAY_CNT_LEN-1:0] w_can_accept;
   logic [WAY_CNT_LEN-1:0] w_n_lead;
   logic [WAY_CNT_LEN-1:0] w_n_in;
   logic [WAY_CNT_LEN-1:0] w_n_out;

   // Lanes after the first invalid one are ignored even if marked valid.
   function automatic logic [WAY_CNT_LEN-1:0] leading_valid(input fetch_packet_t [WAY-1:0] f);
      logic [WAY_CNT_LEN-1:0] n;
      logic                   stop;
      n    = '0;
      stop = 1'b0;
      for (int i = 0; i < WAY; i++) begin
         if (!f[i].valid)
            stop = 1'b1;
         else if (!stop)
            n = n + 1'b1;
      end
      return n;
   endfunction

   always_comb begin
      w_free       = CNT_W'(DEPTH) - r_count;
      w_can_accept = (w_free >= CNT_W'(WAY)) ? WAY_CNT_LEN'(WAY) : WAY_CNT_LEN'(w_free);

      w_n_lead = leading_valid(fetch_in);
      w_n_in   = (w_n_lead > w_can_accept) ? w_can_accept : w_n_lead;

      w_n_out = dispatch_stage_num_can_fetch;
      if (CNT_W'(w_n_out) > r_count)
         w_n_out = WAY_CNT_LEN'(r_count);
      if (w_n_out > WAY_CNT_LEN'(WAY))
         w_n_out = WAY_CNT_LEN'(WAY);
      if (squash)
         w_n_out = '0;
   end

   assign inst_buff_num_can_accept = w_can_accept;

   generate
      for (genvar gi = 0; gi < WAY; gi++) begin : g_out
         fetch_packet_t w_lane;
         always_comb begin
            w_lane = '0;
            if (WAY_CNT_LEN'(gi) < w_n_out) begin
               w_lane       = r_entries[r_head + IDX_W'(gi)];
               w_lane.valid = 1'b1;
            end
         end
         assign inst_buff_out[gi] = w_lane;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset || squash) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + IDX_W'(w_n_out);
         r_tail  <= r_tail + IDX_W'(w_n_in);
         r_count <= r_count + CNT_W'(w_n_in) - CNT_W'(w_n_out);
      end
   end

   // Payload storage carries no reset; only head/tail/count define contents.
   always_ff @(posedge clock) begin
      if (!reset && !squash) begin
         for (int i = 0; i < WAY; i++) begin
            if (WAY_CNT_LEN'(i) < w_n_in)
               r_entries[r_tail + IDX_W'(i)] <= fetch_in[i];
         end
      end
   end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed + light random bench for inst_buffer with a queue scoreboard model.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   localparam int DEPTH = INST_BUFF_DEPTH;

   logic                            clock;
   logic                            reset;
   fetch_packet_t [WAY-1:0]         fetch_in;
   logic          [WAY_CNT_LEN-1:0] inst_buff_num_can_accept;
   fetch_packet_t [WAY-1:0]         inst_buff_out;
   logic          [WAY_CNT_LEN-1:0] dispatch_stage_num_can_fetch;
   logic                            squash;

   inst_buffer #(.DEPTH(DEPTH)) dut (
      .clock                        (clock),
      .reset                        (reset),
      .fetch_in                     (fetch_in),
      .inst_buff_num_can_accept     (inst_buff_num_can_accept),
      .inst_buff_out                (inst_buff_out),
      .dispatch_stage_num_can_fetch (dispatch_stage_num_can_fetch),
      .squash                       (squash)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int            checks = 0;
   int            errors = 0;
   int            step_no = 0;
   fetch_packet_t model_q[$];
   int            m_head = 0;
   int            m_tail = 0;
   logic [31:0]   next_pc = 32'h0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [WAY-1:0] mask, input int disp, input bit sq, input bit rst);
      int            n_lead, can, n_in, n_out, n_valid_seen;
      bit            stop, gap;
      fetch_packet_t exp_lane;
      fetch_packet_t f_copy [WAY];

      @(negedge clock);
      for (int i = 0; i < WAY; i++) begin
         fetch_in[i].valid = mask[i];
         fetch_in[i].pc    = next_pc;
         fetch_in[i].inst  = $urandom;
         f_copy[i]         = fetch_in[i];
         next_pc           = next_pc + 32'd4;
      end
      dispatch_stage_num_can_fetch = WAY_CNT_LEN'(disp);
      squash = sq;
      reset  = rst;

      can = DEPTH - model_q.size();
      if (can > WAY) can = WAY;
      n_lead = 0;
      stop   = 1'b0;
      for (int i = 0; i < WAY; i++) begin
         if (!mask[i]) stop = 1'b1;
         else if (!stop) n_lead++;
      end
      n_in  = (n_lead < can) ? n_lead : can;
      n_out = model_q.size();
      if (disp < n_out) n_out = disp;
      if (WAY < n_out) n_out = WAY;
      if (sq || rst) begin
         n_out = 0;
         n_in  = 0;
      end

      #1;
      if (!rst) begin
         chk("can_accept", 128'(inst_buff_num_can_accept), 128'(can));
         gap = 1'b0;
         n_valid_seen = 0;
         for (int i = 0; i < WAY; i++) begin
            exp_lane = '0;
            if (i < n_out) begin
               exp_lane       = model_q[i];
               exp_lane.valid = 1'b1;
            end
            chk($sformatf("lane%0d", i), 128'(inst_buff_out[i]), 128'(exp_lane));
            if (!inst_buff_out[i].valid) gap = 1'b1;
            else if (!gap) n_valid_seen++;
         end
         chk("lanes_contiguous", 128'(n_valid_seen),
             128'(int'(inst_buff_out[0].valid) + int'(inst_buff_out[1].valid) + int'(inst_buff_out[2].valid)));
      end

      @(posedge clock);
      #1;
      if (rst || sq) begin
         model_q.delete();
         m_head = 0;
         m_tail = 0;
      end else begin
         for (int i = 0; i < n_out; i++) void'(model_q.pop_front());
         for (int i = 0; i < n_in; i++) model_q.push_back(f_copy[i]);
         m_head = (m_head + n_out) % DEPTH;
         m_tail = (m_tail + n_in) % DEPTH;
      end
      chk("count", 128'(dut.r_count), 128'(model_q.size()));
      chk("head", 128'(dut.r_head), 128'(m_head));
      chk("tail", 128'(dut.r_tail), 128'(m_tail));
      chk("count_le_depth", 128'(int'(dut.r_count) <= DEPTH), 128'(1));
      chk("ptr_invariant", 128'((int'(dut.r_tail) - int'(dut.r_head) + DEPTH) % DEPTH),
          128'(int'(dut.r_count) % DEPTH));
      step_no++;
      $display("step %0d: mask=%b disp=%0d sq=%0d rst=%0d in=%0d out=%0d count=%0d",
               step_no, mask, disp, sq, rst, n_in, n_out, model_q.size());
   endtask

   initial begin
      reset = 1'b1;
      squash = 1'b0;
      fetch_in = '0;
      dispatch_stage_num_can_fetch = '0;

      // Reset and post-reset state
      step(3'b000, 0, 0, 1);
      step(3'b000, 0, 0, 1);
      step(3'b000, 0, 0, 0);

      // Fill and present: PCs 0x0/0x4/0x8 from here
      next_pc = 32'h0;
      step(3'b111, 2, 0, 0);
      step(3'b000, 2, 0, 0);
      step(3'b000, 2, 0, 0);

      // Fill to full, overflow dropped, then dequeue
      for (int k = 0; k < 6; k++) step(3'b111, 0, 0, 0);
      step(3'b111, 0, 0, 0);
      chk("full_count", 128'(dut.r_count), 128'(16));
      chk("full_can_accept", 128'(inst_buff_num_can_accept), 128'(0));
      step(3'b000, 3, 0, 0);
      step(3'b000, 3, 0, 0);
      step(3'b000, 1, 0, 0);

      // Squash with count=9, fetch and dispatch active
      step(3'b111, 3, 1, 0);
      step(3'b000, 0, 0, 0);

      // Position head at 14 with 4 resident, then wrap
      for (int k = 0; k < 4; k++) step(3'b111, 3, 0, 0);
      step(3'b011, 3, 0, 0);
      step(3'b111, 2, 0, 0);
      step(3'b001, 0, 0, 0);
      chk("pre_wrap_head", 128'(dut.r_head), 128'(14));
      step(3'b111, 3, 0, 0);
      chk("wrap_head", 128'(dut.r_head), 128'(1));
      chk("wrap_tail", 128'(dut.r_tail), 128'(5));

      // Non-contiguous valid pattern: only lane 0 enters
      step(3'b101, 0, 0, 0);
      chk("noncontig_count", 128'(dut.r_count), 128'(5));

      // Reset mid-fill
      step(3'b111, 0, 0, 0);
      step(3'b111, 2, 0, 1);
      step(3'b000, 0, 0, 0);

      // Random traffic
      for (int k = 0; k < 60; k++)
         step(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
